coin_accumulator: RTL
=====================

Name: coin_accumulator

Overview:
Front-end coin acceptor that sits directly upstream of the vending machine FSM. It registers coin insertions, accumulates credit, and presents the total on money[4:0] with a valid/ack handshake when the customer commits. On cancel or inactivity timeout it returns the credit on a refund channel instead.

Parameters:
MAX_CREDIT, 30, highest accepted credit; a coin that would push credit above this is rejected (must be <= 31)
TIMEOUT_CYCLES, 64, idle cycles in COLLECT with no accepted coin before auto-refund (>= 2)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
coin  input  2  coin code: 00 none, 01 = 5, 10 = 10, 11 = 20; one-cycle pulse per coin
commit  input  1  customer confirms purchase; one-cycle pulse
cancel  input  1  customer requests refund; one-cycle pulse
vend_ack  input  1  downstream FSM consumed money; one-cycle pulse
money  output  5  offered credit, valid while money_valid=1, else 0
money_valid  output  1  credit offered to the vending machine
refund  output  5  refunded amount, valid while refund_valid=1, else 0
refund_valid  output  1  one-cycle refund strobe
coin_reject  output  1  one-cycle pulse: coin returned unaccepted
busy  output  1  1 in any state other than IDLE

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, credit=0, timeout counter=0, all outputs 0. Reset mid-transaction discards credit with no refund strobe.
- Credit register: 5 bits. Sum computed 6 bits wide. Coin accepted if credit+value <= MAX_CREDIT, else coin_reject=1 on the next cycle and credit unchanged.
- All outputs are registered. Effects appear one cycle after the input sample.
- IDLE: nonzero coin -> COLLECT with credit=value. commit, cancel and vend_ack are ignored.
- COLLECT:
  - An accepted coin adds to credit and clears the timeout counter.
  - commit -> OFFER.
  - cancel -> REFUND.
  - Counter reaching TIMEOUT_CYCLES-1 -> REFUND.
  - Priority within a cycle: the coin is applied first, then cancel, then commit, then timeout. A coin plus commit in the same cycle offers the coin-inclusive sum. A coin plus cancel refunds the coin-inclusive sum.
  - A coin rejected for overflow does not clear the counter.
- OFFER:
  - money=credit and money_valid=1, held stable until vend_ack.
  - vend_ack -> IDLE next cycle, with credit=0, money=0 and money_valid=0.
  - cancel without vend_ack -> REFUND. If vend_ack and cancel arrive together, vend_ack wins.
  - Any coin in OFFER is rejected.
  - No timeout in OFFER.
- REFUND: refund=credit and refund_valid=1 for exactly one cycle, then IDLE with credit=0. A coin arriving in REFUND is rejected.
- money_valid and refund_valid are never 1 simultaneously.
- commit in COLLECT with credit 0 is not reachable, because COLLECT is entered only with credit > 0.

Optional Feature:
COIN_SYNC_EN
- Defined:
  - coin, commit and cancel each pass through a 2-flop synchronizer.
  - Rising-edge detection: an event is a 00->nonzero transition for coin, and 0->1 for commit and cancel.
  - This adds 2 cycles of input latency, and held levels produce a single event.
  - vend_ack is not synchronized.
- Undefined: inputs are used directly as synchronous one-cycle pulses. A held input counts once per cycle.

Test Plan:
- Reset: reset=0 mid-COLLECT with credit 15 -> all outputs 0, no refund_valid, busy=0 next sample.
- Coins 5,10 then commit -> money=15, money_valid=1 held until vend_ack; after ack, money_valid=0 and busy=0.
- Coins 20,10 then coin 5 -> third coin gives coin_reject pulse and credit stays 30. Then cancel -> refund=30, refund_valid for 1 cycle.
- Coin 10, then idle for 64 cycles -> refund=10 strobe exactly on timeout, then IDLE.
- Same-cycle events:
  - coin 5 + commit with credit 10 -> money=15.
  - vend_ack + cancel in OFFER -> IDLE with no refund.
  - coin in OFFER -> coin_reject, money unchanged.
- With COIN_SYNC_EN: coin=01 held for 5 cycles -> credit +5 once, money path 2 cycles later than without the macro.

Source files
------------

// File: rtl/coin_accumulator.sv
// rtl/coin_accumulator.sv - coin acceptor front end: credit accumulation, offer handshake, refund
//
// Optional build macro: COIN_SYNC_EN (2-flop synchronizers plus edge detection on coin/commit/cancel)
//
// Ports:
//   clock        rising-edge system clock
//   reset        asynchronous active-low reset
//   coin[1:0]    coin code: 00 none, 01 = 5, 10 = 10, 11 = 20
//   commit       customer confirms purchase
//   cancel       customer requests refund
//   vend_ack     downstream FSM consumed the offered money
//   money[4:0]   offered credit, 0 unless money_valid
//   money_valid  credit offered downstream
//   refund[4:0]  refunded amount, 0 unless refund_valid
//   refund_valid one-cycle refund strobe
//   coin_reject  one-cycle pulse: coin returned unaccepted
//   busy         1 in any state other than IDLE
module coin_accumulator #(
    parameter int MAX_CREDIT     = 30,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] coin,
    input  logic       commit,
    input  logic       cancel,
    input  logic       vend_ack,
    output logic [4:0] money,
    output logic       money_valid,
    output logic [4:0] refund,
    output logic       refund_valid,
    output logic       coin_reject,
    output logic       busy
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [5:0]    MAX_SUM   = 6'(MAX_CREDIT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_OFFER   = 2'd2,
        S_REFUND  = 2'd3
    } state_t;

    state_t        state, next_state;
    logic [4:0]    credit, credit_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [4:0]    money_n, refund_n;
    logic          money_valid_n, refund_valid_n, coin_reject_n;

    // Events seen by the FSM, either raw pulses or synchronized edges.
    logic [1:0] coin_ev;
    logic       commit_ev;
    logic       cancel_ev;

`ifdef COIN_SYNC_EN
    logic [1:0] coin_s1, coin_s2, coin_prev;
    logic       commit_s1, commit_s2, commit_prev;
    logic       cancel_s1, cancel_s2, cancel_prev;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            coin_s1     <= 2'b00;
            coin_s2     <= 2'b00;
            coin_prev   <= 2'b00;
            commit_s1   <= 1'b0;
            commit_s2   <= 1'b0;
            commit_prev <= 1'b0;
            cancel_s1   <= 1'b0;
            cancel_s2   <= 1'b0;
            cancel_prev <= 1'b0;
        end else begin
            coin_s1     <= coin;
            coin_s2     <= coin_s1;
            coin_prev   <= coin_s2;
            commit_s1   <= commit;
            commit_s2   <= commit_s1;
            commit_prev <= commit_s2;
            cancel_s1   <= cancel;
            cancel_s2   <= cancel_s1;
            cancel_prev <= cancel_s2;
        end
    end

    // A held level yields one event: only the idle-to-active transition counts.
    assign coin_ev   = (coin_prev == 2'b00) ? coin_s2 : 2'b00;
    assign commit_ev = commit_s2 & ~commit_prev;
    assign cancel_ev = cancel_s2 & ~cancel_prev;
`else
    assign coin_ev   = coin;
    assign commit_ev = commit;
    assign cancel_ev = cancel;
`endif

    logic [5:0] coin_value;
    logic [5:0] sum;
    logic       coin_present;
    logic       coin_ok;

    always_comb begin
        coin_value = 6'd0;
        case (coin_ev)
            2'b01:   coin_value = 6'd5;
            2'b10:   coin_value = 6'd10;
            2'b11:   coin_value = 6'd20;
            default: coin_value = 6'd0;
        endcase
    end

    // Six-bit sum so an overflowing coin is detected instead of wrapping.
    assign sum          = {1'b0, credit} + coin_value;
    assign coin_present = (coin_ev != 2'b00);
    assign coin_ok      = coin_present && (sum <= MAX_SUM);

    always_comb begin
        next_state     = state;
        credit_n       = credit;
        tcnt_n         = tcnt;
        money_n        = money;
        money_valid_n  = money_valid;
        refund_n       = 5'd0;
        refund_valid_n = 1'b0;
        coin_reject_n  = 1'b0;

        case (state)
            S_IDLE: begin
                money_n       = 5'd0;
                money_valid_n = 1'b0;
                if (coin_present) begin
                    if (coin_ok) begin
                        credit_n   = sum[4:0];
                        tcnt_n     = '0;
                        next_state = S_COLLECT;
                    end else begin
                        coin_reject_n = 1'b1;
                    end
                end
            end

            S_COLLECT: begin
                // The coin is folded in first so commit/cancel see the new sum.
                if (coin_present) begin
                    if (coin_ok) begin
                        credit_n = sum[4:0];
                        tcnt_n   = '0;
                    end else begin
                        coin_reject_n = 1'b1;
                    end
                end
                if (cancel_ev) begin
                    next_state     = S_REFUND;
                    refund_n       = credit_n;
                    refund_valid_n = 1'b1;
                end else if (commit_ev) begin
                    next_state    = S_OFFER;
                    money_n       = credit_n;
                    money_valid_n = 1'b1;
                end else if (!coin_ok) begin
                    // A rejected coin leaves the idle count running.
                    if (tcnt == TCNT_LAST) begin
                        next_state     = S_REFUND;
                        refund_n       = credit_n;
                        refund_valid_n = 1'b1;
                    end else begin
                        tcnt_n = tcnt + 1'b1;
                    end
                end
            end

            S_OFFER: begin
                coin_reject_n = coin_present;
                if (vend_ack) begin
                    next_state    = S_IDLE;
                    credit_n      = 5'd0;
                    money_n       = 5'd0;
                    money_valid_n = 1'b0;
                end else if (cancel_ev) begin
                    next_state     = S_REFUND;
                    money_n        = 5'd0;
                    money_valid_n  = 1'b0;
                    refund_n       = credit;
                    refund_valid_n = 1'b1;
                end
            end

            S_REFUND: begin
                coin_reject_n = coin_present;
                next_state    = S_IDLE;
                credit_n      = 5'd0;
                tcnt_n        = '0;
                money_n       = 5'd0;
                money_valid_n = 1'b0;
            end

            default: begin
                next_state = S_IDLE;
                credit_n   = 5'd0;
                tcnt_n     = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            credit       <= 5'd0;
            tcnt         <= '0;
            money        <= 5'd0;
            money_valid  <= 1'b0;
            refund       <= 5'd0;
            refund_valid <= 1'b0;
            coin_reject  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= next_state;
            credit       <= credit_n;
            tcnt         <= tcnt_n;
            money        <= money_n;
            money_valid  <= money_valid_n;
            refund       <= refund_n;
            refund_valid <= refund_valid_n;
            coin_reject  <= coin_reject_n;
            busy         <= (next_state != S_IDLE);
        end
    end

endmodule
